// File: rtl/multirow_edge_tagger.sv
// multirow_edge_tagger: tags each N-row beat with out-of-image neighbour masks,
// padding-lane flags and line/frame length errors, at a fixed 2-cycle latency.
`default_nettype none

module multirow_edge_tagger #(
    parameter int P_INPUT_ROWS_NUM = 5,
    parameter int P_ROW_DATA_WIDTH = 8,
    parameter int P_RADIUS         = 2,
    parameter int P_DIM_WIDTH      = 12
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic [P_DIM_WIDTH-1:0]                     i_cfg_width,
    input  logic [P_DIM_WIDTH-1:0]                     i_cfg_height,
    input  logic                                       i_v_async,
    input  logic                                       i_h_async,
    input  logic [P_INPUT_ROWS_NUM*P_ROW_DATA_WIDTH-1:0] i_rows_data,
    output logic                                       o_v_async,
    output logic                                       o_h_async,
    output logic [P_INPUT_ROWS_NUM*P_ROW_DATA_WIDTH-1:0] o_rows_data,
    output logic [P_INPUT_ROWS_NUM-1:0]                o_lane_valid,
    output logic [P_RADIUS-1:0]                        o_left_mask,
    output logic [P_RADIUS-1:0]                        o_right_mask,
    output logic [P_INPUT_ROWS_NUM*P_RADIUS-1:0]       o_top_mask,
    output logic [P_INPUT_ROWS_NUM*P_RADIUS-1:0]       o_bottom_mask,
    output logic                                       o_line_err,
    output logic                                       o_frame_err
);

    localparam int N  = P_INPUT_ROWS_NUM;
    localparam int DW = P_DIM_WIDTH;
    localparam int XW = P_DIM_WIDTH + 1;
    localparam int BW = P_INPUT_ROWS_NUM * P_ROW_DATA_WIDTH;
    localparam int MW = P_INPUT_ROWS_NUM * P_RADIUS;

    localparam logic [XW-1:0] N_X     = XW'(N);
    localparam logic [DW-1:0] DIM_MAX = '1;
    localparam logic [DW-1:0] ONE_D   = DW'(1);

    // input register stage
    logic           v_s1;
    logic           h_s1;
    logic [BW-1:0]  data_s1;
    logic [DW-1:0]  cfg_w_s1;
    logic [DW-1:0]  cfg_h_s1;
    logic           h_s1_1d;
    // frame-edge trackers reset high so that a release mid-frame never looks like a v rise
    logic           v_trk;
    logic           v_trk_1d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_s1     <= 1'b0;
            h_s1     <= 1'b0;
            data_s1  <= '0;
            cfg_w_s1 <= '0;
            cfg_h_s1 <= '0;
            h_s1_1d  <= 1'b0;
            v_trk    <= 1'b1;
            v_trk_1d <= 1'b1;
        end else begin
            v_s1     <= i_v_async;
            h_s1     <= i_h_async;
            data_s1  <= i_rows_data;
            cfg_w_s1 <= i_cfg_width;
            cfg_h_s1 <= i_cfg_height;
            h_s1_1d  <= h_s1;
            v_trk    <= i_v_async;
            v_trk_1d <= v_trk;
        end
    end

    logic v_rise;
    logic v_fall;
    logic h_fall;
    assign v_rise = v_trk & ~v_trk_1d;
    assign v_fall = v_trk_1d & ~v_trk;
    assign h_fall = h_s1_1d & ~h_s1;

    logic [DW-1:0] cfg_w_eff;
    logic [DW-1:0] cfg_h_eff;
    assign cfg_w_eff = (cfg_w_s1 == '0) ? ONE_D : cfg_w_s1;
    assign cfg_h_eff = (cfg_h_s1 == '0) ? ONE_D : cfg_h_s1;

    // per-frame state
    logic          armed;
    logic [DW-1:0] width;
    logic [DW-1:0] height;
    logic [DW-1:0] blk_target;
    logic [DW-1:0] col_cnt;
    logic [DW-1:0] row_base;
    logic [DW-1:0] blk_cnt;

    logic [XW-1:0] row_base_sum;
    logic [DW-1:0] row_base_inc;
    logic [DW-1:0] blk_cnt_inc;
    logic [DW-1:0] col_cnt_inc;
    assign row_base_sum = {1'b0, row_base} + N_X;
    assign row_base_inc = row_base_sum[DW] ? DIM_MAX : row_base_sum[DW-1:0];
    assign blk_cnt_inc  = (blk_cnt == DIM_MAX) ? blk_cnt : blk_cnt + ONE_D;
    assign col_cnt_inc  = (col_cnt == DIM_MAX) ? col_cnt : col_cnt + ONE_D;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed      <= 1'b0;
            width      <= '0;
            height     <= '0;
            blk_target <= '0;
            col_cnt    <= '0;
            row_base   <= '0;
            blk_cnt    <= '0;
        end else if (v_rise) begin
            armed      <= 1'b1;
            width      <= cfg_w_eff;
            height     <= cfg_h_eff;
            // constant divisor: ceil(height / N) computed once per frame
            blk_target <= DW'(({1'b0, cfg_h_eff} + N_X - XW'(1)) / N_X);
            col_cnt    <= '0;
            row_base   <= '0;
            blk_cnt    <= '0;
        end else if (armed) begin
            col_cnt <= h_s1 ? col_cnt_inc : '0;
            if (h_fall) begin
                row_base <= row_base_inc;
                blk_cnt  <= blk_cnt_inc;
            end
            if (v_fall) begin
                armed <= 1'b0;
            end
        end else begin
            col_cnt <= '0;
        end
    end

    // a block closing on the same cycle as the frame still counts towards it
    logic [DW-1:0] blk_final;
    logic          line_bad;
    logic          frame_bad;
    assign blk_final = h_fall ? blk_cnt_inc : blk_cnt;
    assign line_bad  = armed & h_fall & (col_cnt != width);
    assign frame_bad = armed & v_fall & (blk_final != blk_target);

    logic                 active;
    logic [P_RADIUS-1:0]  left_c;
    logic [P_RADIUS-1:0]  right_c;
    logic [MW-1:0]        top_c;
    logic [MW-1:0]        bot_c;
    logic [N-1:0]         lv_c;
    logic [XW-1:0]        row_j;
    logic                 lane_ok;
    logic [XW-1:0]        col_x;
    logic [XW-1:0]        width_x;
    logic [XW-1:0]        height_x;

    assign active   = armed & h_s1;
    assign col_x    = {1'b0, col_cnt};
    assign width_x  = {1'b0, width};
    assign height_x = {1'b0, height};

    always_comb begin
        left_c  = '0;
        right_c = '0;
        top_c   = '0;
        bot_c   = '0;
        lv_c    = '0;
        row_j   = '0;
        lane_ok = 1'b0;
        for (int k = 0; k < P_RADIUS; k++) begin
            left_c[k]  = active & (col_x < XW'(k + 1));
            right_c[k] = active & ((col_x + XW'(k + 1)) >= width_x);
        end
        for (int j = 0; j < N; j++) begin
            row_j   = {1'b0, row_base} + XW'(j);
            lane_ok = row_j < height_x;
            lv_c[j] = active & lane_ok;
            for (int k = 0; k < P_RADIUS; k++) begin
                top_c[j*P_RADIUS+k] = active & (~lane_ok | (row_j < XW'(k + 1)));
                bot_c[j*P_RADIUS+k] = active & (~lane_ok | ((row_j + XW'(k + 1)) >= height_x));
            end
        end
    end

    // output register stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_v_async     <= 1'b0;
            o_h_async     <= 1'b0;
            o_rows_data   <= '0;
            o_lane_valid  <= '0;
            o_left_mask   <= '0;
            o_right_mask  <= '0;
            o_top_mask    <= '0;
            o_bottom_mask <= '0;
            o_line_err    <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_v_async     <= v_s1;
            o_h_async     <= h_s1;
            o_rows_data   <= data_s1;
            o_lane_valid  <= lv_c;
            o_left_mask   <= left_c;
            o_right_mask  <= right_c;
            o_top_mask    <= top_c;
            o_bottom_mask <= bot_c;
            o_line_err    <= line_bad;
            o_frame_err   <= frame_bad;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multirow_edge_tagger.sv
// tb_multirow_edge_tagger: directed frames with hand-computed tags, checked 2 cycles later.
`default_nettype none

module tb_multirow_edge_tagger;

    localparam int N   = 5;
    localparam int PW  = 8;
    localparam int R   = 2;
    localparam int DIM = 12;

    logic             clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [DIM-1:0]   i_cfg_width = 12'd8;
    logic [DIM-1:0]   i_cfg_height = 12'd12;
    logic             i_v_async = 1'b0;
    logic             i_h_async = 1'b0;
    logic [N*PW-1:0]  i_rows_data = '0;
    logic             o_v_async;
    logic             o_h_async;
    logic [N*PW-1:0]  o_rows_data;
    logic [N-1:0]     o_lane_valid;
    logic [R-1:0]     o_left_mask;
    logic [R-1:0]     o_right_mask;
    logic [N*R-1:0]   o_top_mask;
    logic [N*R-1:0]   o_bottom_mask;
    logic             o_line_err;
    logic             o_frame_err;

    always #5 clk = ~clk;

    multirow_edge_tagger #(
        .P_INPUT_ROWS_NUM (N),
        .P_ROW_DATA_WIDTH (PW),
        .P_RADIUS         (R),
        .P_DIM_WIDTH      (DIM)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_cfg_width   (i_cfg_width),
        .i_cfg_height  (i_cfg_height),
        .i_v_async     (i_v_async),
        .i_h_async     (i_h_async),
        .i_rows_data   (i_rows_data),
        .o_v_async     (o_v_async),
        .o_h_async     (o_h_async),
        .o_rows_data   (o_rows_data),
        .o_lane_valid  (o_lane_valid),
        .o_left_mask   (o_left_mask),
        .o_right_mask  (o_right_mask),
        .o_top_mask    (o_top_mask),
        .o_bottom_mask (o_bottom_mask),
        .o_line_err    (o_line_err),
        .o_frame_err   (o_frame_err)
    );

    typedef struct packed {
        logic            m;
        logic            v;
        logic            h;
        logic [N*PW-1:0] d;
        logic [N-1:0]    lv;
        logic [R-1:0]    l;
        logic [R-1:0]    r;
        logic [N*R-1:0]  t;
        logic [N*R-1:0]  b;
        logic            le;
        logic            fe;
    } exp_t;

    exp_t e_in = '0;
    exp_t e_d1 = '0;
    exp_t e_d2 = '0;
    int   n_total = 0;
    int   n_bad   = 0;
    bit   armed_x = 1'b0;
    bit   rst_req = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        e_d1 <= e_in;
        e_d2 <= e_d1;
    end

    always @(negedge clk) begin : mon
        exp_t e;
        e = i_rst_n ? e_d2 : '0;
        chk("v", 64'(o_v_async), 64'(e.v));
        chk("h", 64'(o_h_async), 64'(e.h));
        chk("data", 64'(o_rows_data), 64'(e.d));
        chk("line_err", 64'(o_line_err), 64'(e.le));
        chk("frame_err", 64'(o_frame_err), 64'(e.fe));
        if (e.m || !i_rst_n) begin
            chk("lane_valid", 64'(o_lane_valid), 64'(e.lv));
            chk("left", 64'(o_left_mask), 64'(e.l));
            chk("right", 64'(o_right_mask), 64'(e.r));
            chk("top", 64'(o_top_mask), 64'(e.t));
            chk("bottom", 64'(o_bottom_mask), 64'(e.b));
        end
    end

    // one beat; expectation defaults to all masks zero
    task automatic step(input bit v, input bit h, input logic [N*PW-1:0] d);
        @(posedge clk);
        #1;
        i_rst_n     = rst_req;
        i_v_async   = v;
        i_h_async   = h;
        i_rows_data = d;
        e_in        = '0;
        e_in.m      = 1'b1;
        if (rst_req) begin
            e_in.v = v;
            e_in.h = h;
            e_in.d = d;
        end
    endtask

    task automatic exp_m(input logic [N-1:0] lv, input logic [R-1:0] l, input logic [R-1:0] r,
                         input logic [N*R-1:0] t, input logic [N*R-1:0] b);
        e_in.lv = lv;
        e_in.l  = l;
        e_in.r  = r;
        e_in.t  = t;
        e_in.b  = b;
    endtask

    function automatic logic [R-1:0] lmask(input int c);
        case (c)
            0:       return 2'b11;
            1:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [R-1:0] rmask(input int c, input int w);
        if (c == w - 1) return 2'b11;
        if (c == w - 2) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [N*PW-1:0] pix(input logic [7:0] tag, input int c);
        return {tag, 8'(c), 24'h5A0F3C};
    endfunction

    task automatic send_line(input int len, input int wid, input logic [N-1:0] lv,
                             input logic [N*R-1:0] t, input logic [N*R-1:0] b,
                             input bit le, input logic [7:0] tag);
        for (int c = 0; c < len; c++) begin
            step(1'b1, 1'b1, pix(tag, c));
            if (armed_x) exp_m(lv, lmask(c), rmask(c, wid), t, b);
        end
        step(1'b1, 1'b0, '0);
        e_in.le = le;
        step(1'b1, 1'b0, '0);
    endtask

    task automatic frame_start();
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        armed_x = 1'b1;
    endtask

    task automatic frame_end(input bit fe);
        step(1'b0, 1'b0, '0);
        e_in.fe = fe;
        armed_x = 1'b0;
        step(1'b0, 1'b0, '0);
    endtask

    // H=12, N=5: block0 rows 0-4, block1 rows 5-9, block2 rows 10-14
    localparam logic [N*R-1:0] TOP_B0 = 10'b00_00_00_10_11;
    localparam logic [N*R-1:0] TOP_B2 = 10'b11_11_11_00_00;
    localparam logic [N*R-1:0] BOT_B2 = 10'b11_11_11_11_10;
    localparam logic [N*R-1:0] BOT_H5 = 10'b11_10_00_00_00;

    initial begin
        rst_req = 1'b0;
        repeat (3) step(1'b0, 1'b0, '0);
        rst_req = 1'b1;
        repeat (2) step(1'b0, 1'b0, '0);

        // frame A: 3 well-formed blocks
        frame_start();
        send_line(8, 8, 5'b11111, TOP_B0, '0, 1'b0, 8'hA0);
        send_line(8, 8, 5'b11111, '0, '0, 1'b0, 8'hA1);
        send_line(8, 8, 5'b00011, TOP_B2, BOT_B2, 1'b0, 8'hA2);
        frame_end(1'b0);

        // frame B: short first line, only 2 blocks
        frame_start();
        send_line(7, 8, 5'b11111, TOP_B0, '0, 1'b1, 8'hB0);
        send_line(8, 8, 5'b11111, '0, '0, 1'b0, 8'hB1);
        frame_end(1'b1);

        // frame C: reset in the middle of block2, released mid-frame
        frame_start();
        send_line(8, 8, 5'b11111, TOP_B0, '0, 1'b0, 8'hC0);
        send_line(8, 8, 5'b11111, '0, '0, 1'b0, 8'hC1);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, pix(8'hC2, c));
            exp_m(5'b00011, lmask(c), rmask(c, 8), TOP_B2, BOT_B2);
        end
        rst_req = 1'b0;
        armed_x = 1'b0;
        for (int c = 3; c < 6; c++) step(1'b1, 1'b1, pix(8'hC2, c));
        rst_req = 1'b1;
        for (int c = 6; c < 8; c++) step(1'b1, 1'b1, pix(8'hC2, c));
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        send_line(8, 8, '0, '0, '0, 1'b0, 8'hC3);
        frame_end(1'b0);

        // frame D: tagged normally; width change mid-frame is ignored
        frame_start();
        send_line(8, 8, 5'b11111, TOP_B0, '0, 1'b0, 8'hD0);
        i_cfg_width = 12'd16;
        send_line(8, 8, 5'b11111, '0, '0, 1'b0, 8'hD1);
        send_line(8, 8, 5'b00011, TOP_B2, BOT_B2, 1'b0, 8'hD2);
        frame_end(1'b0);

        // frame E: width 16 now in effect, height 5 gives a single block
        i_cfg_height = 12'd5;
        frame_start();
        send_line(16, 16, 5'b11111, TOP_B0, BOT_H5, 1'b0, 8'hE0);
        frame_end(1'b0);

        repeat (3) step(1'b0, 1'b0, '0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multirow_edge_tagger.md
Name: multirow_edge_tagger

Overview:
- Parametrised edge-tagging stage for multi-row pixel streams: each beat carries P_INPUT_ROWS_NUM vertically adjacent pixels, one per lane.
- Generates per-lane, per-offset out-of-image masks for a kernel of radius P_RADIUS.
- Image width and height are runtime inputs latched per frame.
- Also tags lanes that are padding beyond the image bottom, and flags malformed lines and frames.
- Sits between the multi-row line buffer and the windowed filter or padding-insertion stages.

Parameters:
- P_INPUT_ROWS_NUM, 5, lanes (rows) per beat, N.
- P_ROW_DATA_WIDTH, 8, bits per lane pixel.
- P_RADIUS, 2, kernel radius R (>=1); one mask bit per neighbour offset 1..R.
- P_DIM_WIDTH, 12, width of the dimension inputs and of the internal counters.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_cfg_width  in  P_DIM_WIDTH  image width in pixels; sampled at v rise.
- i_cfg_height  in  P_DIM_WIDTH  image height in rows; sampled at v rise.
- i_v_async  in  1  frame valid.
- i_h_async  in  1  line valid; one high period per N-row block.
- i_rows_data  in  N*P_ROW_DATA_WIDTH  lane pixels, lane j at [j*W +: W].
- o_v_async  out  1  delayed i_v_async.
- o_h_async  out  1  delayed i_h_async.
- o_rows_data  out  N*P_ROW_DATA_WIDTH  delayed data.
- o_lane_valid  out  N  bit j=1: lane j holds a real image row.
- o_left_mask  out  R  bit k=1: column-(k+1) is outside the image.
- o_right_mask  out  R  bit k=1: column+(k+1) is outside the image.
- o_top_mask  out  N*R  bit j*R+k=1: row(lane j)-(k+1) < 0.
- o_bottom_mask  out  N*R  bit j*R+k=1: row(lane j)+(k+1) >= height.
- o_line_err  out  1  1-cycle pulse: previous line length differed from width.
- o_frame_err  out  1  1-cycle pulse: block count at frame end differed from ceil(height/N).

Behaviour:
- Reset: all outputs 0, counters 0, armed=0.
- Latency: fixed 2 cycles for every output (input register stage, then output register stage). All mask and flag outputs are cycle-aligned with o_h_async and o_rows_data.
- Frame start and config:
  - v rise = registered v & !v_1d.
  - On v rise: latch width and height, clear counters, set armed=1.
  - A cfg value of 0 is treated as 1.
  - Cfg changes mid-frame are ignored.
  - armed clears on v fall.
- Arming: after reset release mid-frame, masks, lane_valid and err stay 0 and data passes through until the next v rise.
- col_cnt:
  - Increments each cycle registered h is high while armed.
  - Clears when h is low.
  - Saturates at all-ones.
- row_base (absolute row of lane 0):
  - Accumulator: +N at each h fall while armed. No multiplier.
  - Cleared at v rise.
  - blk_cnt increments alongside it.
- Masks (zero whenever h or armed is low), with r_j = row_base + j:
  - left bit k = (col_cnt < k+1).
  - right bit k = (col_cnt + k+1 >= width).
  - top bit j*R+k = (r_j < k+1).
  - bottom bit j*R+k = (r_j + k+1 >= height).
  - lane_valid bit j = (r_j < height).
  - For lanes with lane_valid=0, top and bottom bits are forced to 1.
  - All comparisons use P_DIM_WIDTH+1 bits to avoid wrap.
- o_line_err: at h fall while armed, pulse if the final col_cnt != width.
- o_frame_err:
  - At v fall while armed, pulse if blk_cnt != ceil(height/N).
  - Pulse timing: 2 cycles after the registered fall.
- Simultaneous events:
  - h fall and v fall in the same cycle: row_base still updates; both err checks are evaluated.
  - h high while v low: pass-through only, no counting.

Test Plan:
- N=5, R=2, W=8, H=12, single frame of 3 blocks -> block0: top lane0=2'b11, lane1=2'b10, lanes2-4=00; lane_valid=5'b11111; no errors.
- Same frame, block2 (rows 10-14) -> lane_valid=5'b00011; bottom lane0=2'b10, lane1=2'b11, lanes2-4 forced 2'b11; frame_err=0.
- Columns of any line: col0 -> left=2'b11; col1 -> left=2'b10; col2..5 -> left=00, right=00; col6 -> right=2'b10; col7 -> right=2'b11; all aligned with o_h_async at 2-cycle latency.
- Line of 7 pixels with W=8 -> o_line_err pulses once, 2 cycles after the h fall; a frame of 2 blocks with H=12 -> o_frame_err pulses once after the v fall.
- Assert reset mid-block2, then release mid-frame -> outputs 0 during reset; data passes with masks=0 until the next v rise; the next frame is tagged correctly.
- Change i_cfg_width from 8 to 16 mid-frame -> masks still use 8 for that frame; the next frame uses 16 (right=2'b11 at col15).
